// File: rtl/pix_write_fifo.sv
// Pixel write FIFO between the brush and the framebuffer write port.
// Optional PIX_WRITE_DEDUP_EN drops repeats of the last accepted pixel.
module pix_write_fifo #(
  parameter int RESOLUTION_H = 640,
  parameter int RESOLUTION_V = 480,
  parameter int HPOS_WIDTH   = 10,
  parameter int VPOS_WIDTH   = 9,
  parameter int DEPTH        = 16,
  parameter int ADDR_WIDTH   = $clog2(RESOLUTION_H*RESOLUTION_V),
  parameter int LVL_WIDTH    = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fifopush,
  input  logic [HPOS_WIDTH-1:0] writecounter_x,
  input  logic [VPOS_WIDTH-1:0] writecounter_y,
  input  logic [2:0]            writergb,
  output logic                  fifofull,
  output logic                  fifoempty,
  output logic [LVL_WIDTH-1:0]  level,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [2:0]            mem_wdata,
  output logic [7:0]            drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [HPOS_WIDTH-1:0] x;
    logic [VPOS_WIDTH-1:0] y;
    logic [2:0]            rgb;
  } pix_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_WRITE
  } state_t;

  pix_t             buf_q [DEPTH];
  pix_t             wr_pix;
  pix_t             hold_q;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  state_t           state_q;
  state_t           state_d;
  logic             in_range;
  logic             dup;
  logic             push_ok;
  logic             drop;
  logic             pop;

  assign wr_pix    = '{x: writecounter_x,
                       y: writecounter_y,
                       rgb: writergb};
  assign fifofull  = (level == LVL_WIDTH'(DEPTH));
  assign fifoempty = (level == '0);
  assign in_range  = (32'(writecounter_x) < RESOLUTION_H) &&
                     (32'(writecounter_y) < RESOLUTION_V);

`ifdef PIX_WRITE_DEDUP_EN
  logic last_vld;
  pix_t last_q;

  assign dup = last_vld && (last_q == wr_pix);

  // remember the most recently stored pixel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_vld <= 1'b0;
      last_q   <= '0;
    end else if (push_ok) begin
      last_vld <= 1'b1;
      last_q   <= wr_pix;
    end
  end
`else
  assign dup = 1'b0;
`endif

  assign push_ok = fifopush && !fifofull && in_range && !dup;
  assign drop    = fifopush && (fifofull || !in_range);

  // entry storage, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) buf_q[wptr] <= wr_pix;
  end

  // pointers, occupancy and drop counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      drop_cnt <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_W'(1);
      if (pop)     rptr <= rptr + PTR_W'(1);
      unique case ({push_ok, pop})
        2'b10:   level <= level + LVL_WIDTH'(1);
        2'b01:   level <= level - LVL_WIDTH'(1);
        default: level <= level;
      endcase
      if (drop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // drain state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // drain next state and pop strobe
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifoempty) begin
          pop     = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC:  state_d = S_WRITE;
      S_WRITE: if (mem_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // holding registers and registered memory port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (pop) hold_q <= buf_q[rptr];
      if (state_q == S_CALC) begin
        mem_addr  <= ADDR_WIDTH'(hold_q.y) *
                     ADDR_WIDTH'(RESOLUTION_H) +
                     ADDR_WIDTH'(hold_q.x);
        mem_wdata <= hold_q.rgb;
        mem_we    <= 1'b1;
      end else if (state_q == S_WRITE && mem_ready) begin
        mem_we    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pix_write_fifo.sv
// Directed bench for pix_write_fifo.
// Expected values are hand-computed from the pixel coordinates.
module tb_pix_write_fifo;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fifopush;
  logic [9:0]  writecounter_x;
  logic [8:0]  writecounter_y;
  logic [2:0]  writergb;
  logic        fifofull;
  logic        fifoempty;
  logic [4:0]  level;
  logic        mem_ready;
  logic        mem_we;
  logic [18:0] mem_addr;
  logic [2:0]  mem_wdata;
  logic [7:0]  drop_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int wa[$];
  int wd[$];
  logic [18:0] a0;
  logic [2:0]  d0;

  pix_write_fifo dut (
    .clk(clk),
    .reset_n(reset_n),
    .fifopush(fifopush),
    .writecounter_x(writecounter_x),
    .writecounter_y(writecounter_y),
    .writergb(writergb),
    .fifofull(fifofull),
    .fifoempty(fifoempty),
    .level(level),
    .mem_ready(mem_ready),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d",
             tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    fifopush       = 1'b0;
    writecounter_x = '0;
    writecounter_y = '0;
    writergb       = '0;
    mem_ready      = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic push(input int x, input int y,
                      input int rgb);
    fifopush       = 1'b1;
    writecounter_x = 10'(x);
    writecounter_y = 9'(y);
    writergb       = 3'(rgb);
    tick();
    fifopush       = 1'b0;
  endtask

  task automatic drain(input int cycles);
    wa.delete();
    wd.delete();
    for (int i = 0; i < cycles; i++) begin
      if (mem_we && mem_ready) begin
        wa.push_back(int'(mem_addr));
        wd.push_back(int'(mem_wdata));
      end
      tick();
    end
  endtask

  initial begin
    do_reset();
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_level", level, 0);
    chk("rst_empty", fifoempty, 1);
    chk("rst_full", fifofull, 0);

    // single push, latency 3
    mem_ready = 1'b1;
    push(5, 2, 5);
    chk("t1_lvl1", level, 1);
    chk("t1_we_n1", mem_we, 0);
    tick();
    chk("t1_lvl0", level, 0);
    chk("t1_we_n2", mem_we, 0);
    tick();
    chk("t1_we_n3", mem_we, 1);
    chk("t1_addr", mem_addr, 1285);
    chk("t1_data", mem_wdata, 5);
    tick();
    chk("t1_we_off", mem_we, 0);
    chk("t1_empty", fifoempty, 1);

    // fill with port blocked, overflow, then drain in order
    do_reset();
    for (int i = 0; i < 16; i++) push(i, 1, i);
    chk("t2_lvl15", level, 15);
    chk("t2_nfull", fifofull, 0);
    push(16, 1, 0);
    chk("t2_lvl16", level, 16);
    chk("t2_full", fifofull, 1);
    chk("t2_drop0", drop_cnt, 0);
    push(17, 1, 1);
    chk("t2_drop1", drop_cnt, 1);
    chk("t2_lvl_hold", level, 16);
    mem_ready = 1'b1;
    drain(80);
    chk("t2_nwr", wa.size(), 17);
    for (int k = 0; k < 17 && k < wa.size(); k++) begin
      chk("t2_addr", wa[k], 640 + k);
      chk("t2_data", wd[k], k % 8);
    end
    chk("t2_empty", fifoempty, 1);

    // corner address and out-of-range drops
    do_reset();
    mem_ready = 1'b1;
    push(639, 479, 7);
    push(1023, 10, 3);
    chk("t3_drop_x", drop_cnt, 1);
    push(0, 480, 3);
    chk("t3_drop_y", drop_cnt, 2);
    drain(15);
    chk("t3_nwr", wa.size(), 1);
    if (wa.size() > 0) begin
      chk("t3_addr", wa[0], 307199);
      chk("t3_data", wd[0], 7);
    end

    // back-pressure hold
    do_reset();
    push(3, 4, 2);
    tick();
    tick();
    chk("t4_we", mem_we, 1);
    a0 = mem_addr;
    d0 = mem_wdata;
    chk("t4_addr", a0, 2563);
    chk("t4_data", d0, 2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_we_hold", mem_we, 1);
      chk("t4_addr_hold", mem_addr, 2563);
      chk("t4_data_hold", mem_wdata, 2);
    end
    mem_ready = 1'b1;
    tick();
    chk("t4_we_done", mem_we, 0);
    drain(6);
    chk("t4_no_more", wa.size(), 0);

    // reset mid-write
    do_reset();
    for (int i = 0; i < 9; i++) push(i, 3, 1);
    chk("t5_lvl8", level, 8);
    chk("t5_we", mem_we, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_we_rst", mem_we, 0);
    chk("t5_lvl_rst", level, 0);
    chk("t5_empty_rst", fifoempty, 1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    mem_ready = 1'b1;
    drain(20);
    chk("t5_nwr", wa.size(), 0);

    // duplicate pixels
    do_reset();
    mem_ready = 1'b1;
    push(7, 7, 2);
    push(7, 7, 2);
    push(8, 7, 2);
    drain(20);
    chk("t6_drop", drop_cnt, 0);
`ifdef PIX_WRITE_DEDUP_EN
    chk("t6_nwr", wa.size(), 2);
    if (wa.size() >= 2) begin
      chk("t6_a0", wa[0], 4487);
      chk("t6_a1", wa[1], 4488);
    end
`else
    chk("t6_nwr", wa.size(), 3);
    if (wa.size() >= 3) begin
      chk("t6_a0", wa[0], 4487);
      chk("t6_a1", wa[1], 4487);
      chk("t6_a2", wa[2], 4488);
    end
`endif

    // drop counter saturation
    do_reset();
    fifopush       = 1'b1;
    writecounter_x = 10'd700;
    writecounter_y = 9'd0;
    repeat (254) tick();
    chk("t7_drop254", drop_cnt, 254);
    repeat (6) tick();
    chk("t7_sat", drop_cnt, 255);
    chk("t7_lvl", level, 0);
    fifopush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
